// File: rtl/div_unit.sv
// Iterative restoring divider for RV32M DIV/DIVU/REM/REMU with a valid/ready handshake.
// One quotient bit per cycle; divide-by-zero and signed overflow bypass the iteration.
module div_unit #(
    parameter int unsigned data_width = 6'd32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            div_op,
    input  logic [data_width-1:0] data_a,
    input  logic [data_width-1:0] data_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [data_width-1:0] result,
    input  logic                  flush
);

    localparam int unsigned cnt_w = (data_width > 1) ? $clog2(data_width) : 1;
    localparam logic [cnt_w-1:0] last_cnt = cnt_w'(data_width - 1);
    localparam logic [data_width-1:0] min_neg = {1'b1, {(data_width-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic [cnt_w-1:0]      cnt_q, cnt_d;
    logic [1:0]            op_q, op_d;
    logic                  sign_a_q, sign_a_d;
    logic                  sign_b_q, sign_b_d;
    logic [data_width-1:0] rem_q, rem_d;
    logic [data_width-1:0] quo_q, quo_d;
    logic [data_width-1:0] dvs_q, dvs_d;
    logic [data_width-1:0] res_q, res_d;

    logic                  signed_op;
    logic                  a_neg, b_neg;
    logic                  accept, div_zero, overflow;
    logic [data_width-1:0] abs_a, abs_b;
    logic [data_width:0]   rem_shift, diff;
    logic [data_width-1:0] step_rem, step_quo;
    logic [data_width-1:0] fin_rem, fin_quo;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = out_valid ? res_q : '0;

    // NOTE: every signal assigned here gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        res_d    = res_q;

        signed_op = ~div_op[0];
        a_neg     = signed_op & data_a[data_width-1];
        b_neg     = signed_op & data_b[data_width-1];
        abs_a     = a_neg ? -data_a : data_a;
        abs_b     = b_neg ? -data_b : data_b;
        accept    = in_valid & in_ready & ~flush;
        div_zero  = (data_b == '0);
        overflow  = signed_op & (data_a == min_neg) & (data_b == '1);

        // One restoring step: shift in the next dividend bit, subtract if it fits.
        rem_shift = {rem_q, quo_q[data_width-1]};
        diff      = rem_shift - {1'b0, dvs_q};
        step_rem  = diff[data_width] ? rem_shift[data_width-1:0] : diff[data_width-1:0];
        step_quo  = {quo_q[data_width-2:0], ~diff[data_width]};
        fin_quo   = (sign_a_q ^ sign_b_q) ? -step_quo : step_quo;
        fin_rem   = sign_a_q ? -step_rem : step_rem;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d     = div_op;
                    sign_a_d = a_neg;
                    sign_b_d = b_neg;
                    cnt_d    = '0;
                    if (div_zero) begin
                        res_d   = div_op[1] ? data_a : '1;
                        state_d = DONE;
                    end else if (overflow) begin
                        res_d   = div_op[1] ? '0 : data_a;
                        state_d = DONE;
                    end else begin
                        rem_d   = '0;
                        quo_d   = abs_a;
                        dvs_d   = abs_b;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + cnt_w'(1);
                if (cnt_q == last_cnt) begin
                    res_d   = op_q[1] ? fin_rem : fin_quo;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (flush) state_d = IDLE;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            res_q    <= res_d;
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: vector table of hand-computed results and latencies,
// plus directed sequences for backpressure, flush and mid-operation reset.
module tb_div_unit;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  div_op;
    logic [31:0] data_a;
    logic [31:0] data_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        flush;

    int errors = 0;
    int checks = 0;

    div_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .div_op    (div_op),
        .data_a    (data_a),
        .data_b    (data_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flush     (flush)
    );

    always #5 clk = ~clk;

    // edges: rising edges after the accept edge until out_valid is seen (0 = bypass).
    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          edges;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a request for one edge; caller ensures the unit is idle.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        div_op   = op;
        data_a   = a;
        data_b   = b;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output logic [31:0] res, output int edges);
        edges = 0;
        while (!out_valid && edges < 64) begin
            step();
            edges++;
        end
        res = result;
    endtask

    initial begin
        logic [31:0] res;
        int          edges;
        int          bad;

        vecs = '{
            '{"divu_100_7",     OP_DIVU, 32'd100,        32'd7,          32'd14,         32},
            '{"remu_100_7",     OP_REMU, 32'd100,        32'd7,          32'd2,          32},
            '{"div_m7_2",       OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32},
            '{"rem_m7_2",       OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  32},
            '{"div_7_m2",       OP_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32},
            '{"rem_7_m2",       OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          32},
            '{"div_m7_m2",      OP_DIV,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32},
            '{"rem_m7_m2",      OP_REM,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'hFFFF_FFFF,  32},
            '{"div_5_0",        OP_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  0},
            '{"rem_5_0",        OP_REM,  32'd5,          32'd0,          32'd5,          0},
            '{"divu_5_0",       OP_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,  0},
            '{"remu_m5_0",      OP_REMU, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  0},
            '{"rem_m5_0",       OP_REM,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  0},
            '{"div_ovf",        OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  0},
            '{"rem_ovf",        OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          0},
            '{"divu_min_m1",    OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32},
            '{"remu_min_m1",    OP_REMU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32},
            '{"divu_max_1",     OP_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32},
            '{"div_min_1",      OP_DIV,  32'h8000_0000,  32'd1,          32'h8000_0000,  32},
            '{"rem_min_3",      OP_REM,  32'h8000_0000,  32'd3,          32'hFFFF_FFFE,  32}
        };

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        div_op    = 2'b00;
        data_a    = '0;
        data_b    = '0;
        out_ready = 1'b1;
        flush     = 1'b0;
        repeat (2) step();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", result, 32'd0);
        rst_n = 1'b1;
        step();

        foreach (vecs[i]) begin
            check({vecs[i].name, "_ready"}, 32'(in_ready), 32'd1);
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(res, edges);
            check(vecs[i].name, res, vecs[i].exp);
            check({vecs[i].name, "_lat"}, 32'(edges), 32'(vecs[i].edges));
            step();
            check({vecs[i].name, "_idle"}, 32'(in_ready), 32'd1);
            check({vecs[i].name, "_res0"}, result, 32'd0);
        end

        // Backpressure: result held and new requests ignored while DONE waits.
        out_ready = 1'b0;
        issue(OP_DIVU, 32'd100, 32'd7);
        wait_done(res, edges);
        check("bp_result", res, 32'd14);
        div_op   = OP_DIVU;
        data_a   = 32'd9;
        data_b   = 32'd3;
        in_valid = 1'b1;
        bad = 0;
        repeat (10) begin
            step();
            if (result !== 32'd14 || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
        end
        check("bp_hold", 32'(bad), 32'd0);
        out_ready = 1'b1;
        step();
        check("bp_release_idle", 32'(in_ready), 32'd1);
        check("bp_release_valid", 32'(out_valid), 32'd0);
        step();
        check("bp_next_accept", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        wait_done(res, edges);
        check("bp_next_result", res, 32'd3);
        check("bp_next_lat", 32'(edges), 32'd32);
        step();

        // Flush at CALC cycle 15 discards the operation.
        issue(OP_DIVU, 32'd100, 32'd7);
        repeat (14) step();
        check("kill_mid_busy", 32'(in_ready), 32'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("kill_ready", 32'(in_ready), 32'd1);
        check("kill_valid", 32'(out_valid), 32'd0);
        bad = 0;
        repeat (40) begin
            step();
            if (out_valid !== 1'b0) bad++;
        end
        check("kill_no_valid", 32'(bad), 32'd0);

        // Flush beats a simultaneous accept.
        div_op   = OP_DIVU;
        data_a   = 32'd9;
        data_b   = 32'd3;
        in_valid = 1'b1;
        flush    = 1'b1;
        step();
        in_valid = 1'b0;
        flush    = 1'b0;
        check("flush_vs_accept", 32'(in_ready), 32'd1);

        // Reset mid-CALC.
        issue(OP_DIVU, 32'd100, 32'd7);
        repeat (10) step();
        rst_n = 1'b0;
        step();
        check("rst_calc_ready", 32'(in_ready), 32'd1);
        check("rst_calc_valid", 32'(out_valid), 32'd0);
        check("rst_calc_result", result, 32'd0);
        rst_n = 1'b1;
        step();

        // Reset while DONE waits for out_ready.
        out_ready = 1'b0;
        issue(OP_DIV, 32'd5, 32'd0);
        check("rst_done_pre", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        step();
        check("rst_done_ready", 32'(in_ready), 32'd1);
        check("rst_done_valid", 32'(out_valid), 32'd0);
        check("rst_done_result", result, 32'd0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        step();

        issue(OP_DIVU, 32'd9, 32'd3);
        wait_done(res, edges);
        check("post_rst_divu_9_3", res, 32'd3);
        check("post_rst_lat", 32'(edges), 32'd32);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
